i2s_tx_scheduler: RTL and testbench
===================================

// Module: i2s_tx_scheduler
// PURPOSE
//  Sequences the i2s_tx serializer from a stereo sample stream. Buffers {left,right} pairs
//  in a FIFO, holds i2s_tx in reset until primed, then presents one pair per I2S frame by
//  tracking wclk. Handles start/stop, mute, underrun reporting and frame strobes.
// PARAMETERS
//  ADDR_W      3  FIFO address width; depth = 2**ADDR_W pairs
//  PRIME_LEVEL 4  FIFO pairs required before PRIME->RUN (1..2**ADDR_W)
// PORTS
//  sysclk       in   1       system clock, same clock as i2s_tx
//  rst_n        in   1       asynchronous active-low reset
//  enable       in   1       level: 1 = start/keep running, 0 = request stop
//  mute         in   1       level: force din_left/din_right to 0 in RUN, FIFO still popped
//  flush        in   1       pulse: empty the FIFO; honoured only in IDLE
//  s_valid      in   1       input pair valid
//  s_ready      out  1       FIFO can accept; equals !full
//  s_left       in   16      left sample
//  s_right      in   16      right sample
//  wclk_in      in   1       wclk from i2s_tx
//  tx_rst       out  1       active-high reset to i2s_tx
//  din_left     out  16      to i2s_tx din_left
//  din_right    out  16      to i2s_tx din_right
//  fifo_level   out  ADDR_W+1 pairs currently stored
//  frame_strobe out  1       1-cycle pulse per frame boundary in RUN
//  underrun     out  1       sticky: frame boundary hit empty FIFO in RUN
//  underrun_clr in   1       pulse: clears underrun (set wins if same cycle)
//  state        out  2       IDLE=0, PRIME=1, RUN=2, STOP=3
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, FIFO empty, tx_rst=1, din_*=0, frame_strobe=0,
//   underrun=0, wclk_q=0. All outputs registered except s_ready/fifo_level (from FIFO regs).
//  Frame boundary fb = wclk_in & ~wclk_q (wclk rise, registered compare, no synchronizer).
//   i2s_tx latches din_right on the edge that raises wclk; fb is seen 1 cycle later, so
//   din_* updates at fb never corrupt the word being latched. din_left latched at wclk fall.
//  FIFO: push when s_valid&s_ready, any state. Pop only at fb in RUN with FIFO non-empty.
//   Push+pop same cycle: level unchanged. Push into empty FIFO at a fb: pop sees empty
//   (no bypass), underrun sets, push stored. Pointers wrap modulo 2**ADDR_W.
//  IDLE: tx_rst=1, din_*=0. flush empties FIFO (flush with concurrent push: FIFO ends empty).
//   enable=1 -> PRIME next cycle.
//  PRIME: tx_rst=1. enable=0 -> IDLE. fifo_level>=PRIME_LEVEL -> RUN; din_*=0 on entry.
//  RUN: tx_rst=0. First wclk rise latches the zero right word (silent half-frame), then
//   each fb: frame_strobe=1; if non-empty pop pair -> din_left/din_right (0 if mute);
//   if empty -> din_*=0, underrun=1, stay RUN. enable=0 sampled at a fb -> STOP at that fb
//   with no pop, din_*=0.
//  STOP: tx_rst=0, din_*=0, no pops, frame_strobe still pulses. At the 1st fb in STOP -> IDLE
//   (one full silent frame transmitted) and tx_rst=1 next cycle. enable=1 in STOP is ignored.
//  mute changes take effect at the next pop only; already-presented din_* not altered.
//  Reset mid-frame: i2s_tx forced into reset via tx_rst=1 asynchronously; FIFO contents lost.
// TESTING
//  T1 prime: enable=1, push 4 pairs (L=16'h1001.., R=16'h2001..) -> RUN when level=4,
//   tx_rst falls; serialized stream = R0=0, then L=1001/R=2001, 1002/2002 ... in order.
//  T2 underrun: PRIME_LEVEL=1, push 1 pair, no more -> 2nd fb gives din_*=0, underrun=1;
//   underrun_clr pulse -> 0; clr coincident with new underrun -> stays 1.
//  T3 full/backpressure: in IDLE push 9 pairs with ADDR_W=3 -> s_ready=0 after 8, level=8,
//   9th held; flush -> level=0, s_ready=1.
//  T4 stop: RUN with 4 queued, drop enable -> STOP at next fb, level unchanged, one silent
//   frame, IDLE at following fb, tx_rst=1; no sample popped after enable low.
//  T5 mute+reset: mute=1 mid-RUN -> popped pairs transmit as 0, level still decrements per fb;
//   async rst_n pulse mid-word -> all outputs to reset values without waiting for sysclk.

Source files
------------

// File: rtl/i2s_tx_scheduler.sv
// Feeds the i2s_tx serializer one {left,right} pair per I2S frame from a small pair FIFO,
// holding the serializer in reset until enough pairs are buffered and draining it cleanly on stop.
module i2s_tx_scheduler #(
   parameter int ADDR_W      = 3,
   parameter int PRIME_LEVEL = 4
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              mute,
   input  logic              flush,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [15:0]       s_left,
   input  logic [15:0]       s_right,
   input  logic              wclk_in,
   output logic              tx_rst,
   output logic [15:0]       din_left,
   output logic [15:0]       din_right,
   output logic [ADDR_W:0]   fifo_level,
   output logic              frame_strobe,
   output logic              underrun,
   input  logic              underrun_clr,
   output logic [1:0]        state
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] PRIME_L = (ADDR_W+1)'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                wclk_q;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     level_q, level_d;
   logic [31:0]         mem_q [DEPTH];
   logic                tx_rst_q, tx_rst_d;
   logic [15:0]         din_left_q, din_left_d;
   logic [15:0]         din_right_q, din_right_d;
   logic                strobe_q, strobe_d;
   logic                underrun_q, underrun_d;

   logic fb, empty, full, push, pop, do_flush;

   // fb is one cycle after the wclk rise, so i2s_tx has already latched the previous right word
   assign fb       = wclk_in & ~wclk_q;
   assign empty    = (level_q == '0);
   assign full     = (level_q == DEPTH_L);
   assign push     = s_valid & ~full;
   assign do_flush = flush & (state_q == IDLE);
   assign pop      = fb & (state_q == RUN) & enable & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      din_left_d  = din_left_q;
      din_right_d = din_right_q;
      strobe_d    = 1'b0;
      underrun_d  = underrun_q & ~underrun_clr;
      case (state_q)
         IDLE: begin
            din_left_d  = '0;
            din_right_d = '0;
            if (enable) state_d = PRIME;
         end
         PRIME: begin
            din_left_d  = '0;
            din_right_d = '0;
            if (!enable)               state_d = IDLE;
            else if (level_q >= PRIME_L) state_d = RUN;
         end
         RUN: begin
            if (fb) begin
               strobe_d = 1'b1;
               if (!enable) begin
                  state_d     = STOP;
                  din_left_d  = '0;
                  din_right_d = '0;
               end else if (!empty) begin
                  din_left_d  = mute ? 16'd0 : mem_q[rd_ptr_q][31:16];
                  din_right_d = mute ? 16'd0 : mem_q[rd_ptr_q][15:0];
               end else begin
                  din_left_d  = '0;
                  din_right_d = '0;
                  underrun_d  = 1'b1;
               end
            end
         end
         STOP: begin
            din_left_d  = '0;
            din_right_d = '0;
            if (fb) begin
               strobe_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      tx_rst_d = (state_d == IDLE) || (state_d == PRIME);
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wclk_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         tx_rst_q    <= 1'b1;
         din_left_q  <= '0;
         din_right_q <= '0;
         strobe_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wclk_q      <= wclk_in;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         tx_rst_q    <= tx_rst_d;
         din_left_q  <= din_left_d;
         din_right_q <= din_right_d;
         strobe_q    <= strobe_d;
         underrun_q  <= underrun_d;
      end
   end

   // Storage needs no reset: the pointers define what is valid
   always_ff @(posedge sysclk) begin
      if (push && !do_flush) mem_q[wr_ptr_q] <= {s_left, s_right};
   end

   assign s_ready      = ~full;
   assign fifo_level   = level_q;
   assign tx_rst       = tx_rst_q;
   assign din_left     = din_left_q;
   assign din_right    = din_right_q;
   assign frame_strobe = strobe_q;
   assign underrun     = underrun_q;
   assign state        = state_q;

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: wclk is driven by hand, a queue models the pair FIFO.
module tb_i2s_tx_scheduler;

   logic        sysclk = 1'b0;
   logic        rst_n;
   logic        enable, mute, flush, s_valid, wclk_in, underrun_clr;
   logic        s_ready, tx_rst, frame_strobe, underrun;
   logic [15:0] s_left, s_right, din_left, din_right;
   logic [3:0]  fifo_level;
   logic [1:0]  state;

   int errors = 0;
   int checks = 0;
   logic [31:0] sb[$];

   i2s_tx_scheduler #(.ADDR_W(3), .PRIME_LEVEL(4)) dut (
      .sysclk(sysclk), .rst_n(rst_n), .enable(enable), .mute(mute), .flush(flush),
      .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
      .wclk_in(wclk_in), .tx_rst(tx_rst), .din_left(din_left), .din_right(din_right),
      .fifo_level(fifo_level), .frame_strobe(frame_strobe), .underrun(underrun),
      .underrun_clr(underrun_clr), .state(state)
   );

   always #5 sysclk = ~sysclk;

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
      chk("s_ready", 32'(s_ready), 32'(sb.size() < 8));
      s_valid = 1'b1; s_left = l; s_right = r;
      tick();
      s_valid = 1'b0;
      if (sb.size() < 8) sb.push_back({l, r});
   endtask

   // Raise wclk; after one edge the frame-boundary effects are visible
   task automatic rise();
      wclk_in = 1'b1;
      tick();
   endtask

   task automatic finish_frame();
      tick();
      chk("strobe_width", 32'(frame_strobe), 32'd0);
      repeat (2) tick();
      wclk_in = 1'b0;
      repeat (4) tick();
   endtask

   task automatic check_pop(input string tag, input bit muted);
      logic [31:0] e;
      e = sb.pop_front();
      chk({tag, "_strobe"}, 32'(frame_strobe), 32'd1);
      chk({tag, "_left"},   32'(din_left),  muted ? 32'd0 : 32'(e[31:16]));
      chk({tag, "_right"},  32'(din_right), muted ? 32'd0 : 32'(e[15:0]));
      chk({tag, "_level"},  32'(fifo_level), 32'(sb.size()));
   endtask

   task automatic check_silent(input string tag, input logic [1:0] exp_state, input bit exp_txrst);
      chk({tag, "_strobe"}, 32'(frame_strobe), 32'd1);
      chk({tag, "_left"},   32'(din_left),  32'd0);
      chk({tag, "_right"},  32'(din_right), 32'd0);
      chk({tag, "_level"},  32'(fifo_level), 32'(sb.size()));
      chk({tag, "_state"},  32'(state), 32'(exp_state));
      chk({tag, "_txrst"},  32'(tx_rst), 32'(exp_txrst));
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; mute = 1'b0; flush = 1'b0; s_valid = 1'b0;
      wclk_in = 1'b0; underrun_clr = 1'b0; s_left = '0; s_right = '0;
      repeat (3) tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_txrst", 32'(tx_rst), 32'd1);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd1);
      chk("rst_din",   32'({din_left, din_right}), 32'd0);
      chk("rst_flags", 32'({frame_strobe, underrun}), 32'd0);
      rst_n = 1'b1;
      tick();

      // Backpressure in IDLE: nine offered, eight stored
      for (int i = 0; i < 9; i++) push_pair(16'h3000 + 16'(i), 16'h4000 + 16'(i));
      chk("full_level", 32'(fifo_level), 32'd8);
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_state", 32'(state), 32'd0);
      flush = 1'b1; s_valid = 1'b1; s_left = 16'hdead; s_right = 16'hbeef;
      tick();
      flush = 1'b0; s_valid = 1'b0;
      sb.delete();
      chk("flush_level", 32'(fifo_level), 32'd0);
      chk("flush_ready", 32'(s_ready), 32'd1);

      // Priming: RUN only once four pairs are buffered
      enable = 1'b1;
      tick();
      chk("prime_state", 32'(state), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         push_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
         chk("prime_hold", 32'(state), 32'd1);
      end
      chk("prime_txrst", 32'(tx_rst), 32'd1);
      tick();
      chk("run_state", 32'(state), 32'd2);
      chk("run_txrst", 32'(tx_rst), 32'd0);
      chk("run_din0",  32'({din_left, din_right}), 32'd0);

      rise(); check_pop("f1", 1'b0); finish_frame();
      rise(); check_pop("f2", 1'b0); finish_frame();

      // Mute affects the next pop only, FIFO still drains
      mute = 1'b1;
      chk("mute_hold", 32'({din_left, din_right}), {16'h1002, 16'h2002});
      rise(); check_pop("f3m", 1'b1); finish_frame();
      mute = 1'b0;
      rise(); check_pop("f4", 1'b0); finish_frame();

      // Underrun: sticky, clearable, set wins over clear
      chk("pre_underrun", 32'(underrun), 32'd0);
      rise();
      check_silent("ur", 2'd2, 1'b0);
      chk("ur_flag", 32'(underrun), 32'd1);
      finish_frame();
      underrun_clr = 1'b1; tick(); underrun_clr = 1'b0; tick();
      chk("ur_clr", 32'(underrun), 32'd0);
      underrun_clr = 1'b1;
      rise();
      underrun_clr = 1'b0;
      chk("ur_set_wins", 32'(underrun), 32'd1);
      finish_frame();

      // Stop: no pops after enable drops, one silent frame, then IDLE
      for (int i = 5; i <= 8; i++) push_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
      chk("stop_level0", 32'(fifo_level), 32'd4);
      enable = 1'b0;
      tick();
      chk("stop_wait", 32'(state), 32'd2);
      rise(); check_silent("stop1", 2'd3, 1'b0); finish_frame();
      rise(); check_silent("stop2", 2'd0, 1'b1); finish_frame();
      chk("idle_level", 32'(fifo_level), 32'd4);

      // Restart with the kept pairs, then async reset mid-frame
      enable = 1'b1;
      tick(); tick();
      chk("rerun_state", 32'(state), 32'd2);
      rise(); check_pop("f5", 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_txrst", 32'(tx_rst), 32'd1);
      chk("arst_din",   32'({din_left, din_right}), 32'd0);
      chk("arst_level", 32'(fifo_level), 32'd0);
      chk("arst_flags", 32'({frame_strobe, underrun}), 32'd0);
      sb.delete();
      enable = 1'b0; wclk_in = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_state", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
